// File: rtl/proc_pkg.sv
// Shared definitions for the proc_ctrl slice: opcodes, FSM states, instruction fields.
package proc_pkg;

    localparam int unsigned DATA_W   = 4;
    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned REG_AW   = 2;
    localparam int unsigned INSTR_W  = 9;

    localparam int unsigned OPC_HI = 8;
    localparam int unsigned OPC_LO = 6;
    localparam int unsigned RD_HI  = 5;
    localparam int unsigned RD_LO  = 4;
    localparam int unsigned RS_HI  = 3;
    localparam int unsigned RS_LO  = 2;
    localparam int unsigned IMM_HI = 3;
    localparam int unsigned IMM_LO = 0;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_LDI  = 3'b101,
        OP_JZ   = 3'b110,
        OP_HALT = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

endpackage

// File: rtl/proc_regfile.sv
// 4x4 register file: one synchronous write port, two async read ports, debug bus.
module proc_regfile
    import proc_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       we_i,
    input  logic [REG_AW-1:0]          waddr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic [REG_AW-1:0]          raddr_a_i,
    input  logic [REG_AW-1:0]          raddr_b_i,
    output logic [DATA_W-1:0]          rdata_a_o,
    output logic [DATA_W-1:0]          rdata_b_o,
    output logic [NUM_REGS*DATA_W-1:0] dbg_o
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

    // Reset has priority so no write lands in a reset cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];
    assign dbg_o     = regs_q;

endmodule

// File: rtl/proc_ctrl.sv
// Multi-cycle fetch/decode/exec/writeback controller with external ALU.
// Optional PROC_CTRL_JZ_EN adds z_flag and makes opcode 110 a conditional jump.
module proc_ctrl
    import proc_pkg::*;
#(
    parameter int PROG_LEN = 16,
    parameter int IMEM_AW  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       fetch_req,
    output logic [IMEM_AW-1:0]         instr_addr,
    input  logic                       instr_valid,
    input  logic [INSTR_W-1:0]         instr_data,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    output logic [2:0]                 alu_opcode,
    input  logic [DATA_W-1:0]          alu_result,
    output logic                       busy,
    output logic                       halted,
`ifdef PROC_CTRL_JZ_EN
    output logic                       z_flag,
`endif
    output logic [NUM_REGS*DATA_W-1:0] rf_dbg
);

    localparam logic [IMEM_AW-1:0] PC_LAST = IMEM_AW'(PROG_LEN - 1);

    state_e               state_q;
    logic [IMEM_AW-1:0]   pc_q;
    logic [INSTR_W-1:0]   ir_q;
    logic [DATA_W-1:0]    result_q;
    logic                 fetch_req_q;
    logic [IMEM_AW-1:0]   instr_addr_q;
    logic [DATA_W-1:0]    alu_a_q;
    logic [DATA_W-1:0]    alu_b_q;
    logic [2:0]           alu_opcode_q;
    logic                 busy_q;
    logic                 halted_q;
`ifdef PROC_CTRL_JZ_EN
    logic                 z_q;
`endif

    opcode_e              opc;
    logic [REG_AW-1:0]    rd;
    logic [REG_AW-1:0]    rs;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    rdata_a;
    logic [DATA_W-1:0]    rdata_b;
    logic                 rf_we;
    logic [DATA_W-1:0]    wb_data_d;
    logic [IMEM_AW-1:0]   pc_adv_d;
    logic [IMEM_AW-1:0]   pc_jump_d;

    assign opc = opcode_e'(ir_q[OPC_HI:OPC_LO]);
    assign rd  = ir_q[RD_HI:RD_LO];
    assign rs  = ir_q[RS_HI:RS_LO];
    assign imm = ir_q[IMM_HI:IMM_LO];

    assign rf_we     = (state_q == ST_WB);
    assign wb_data_d = (opc == OP_LDI) ? imm : result_q;
    assign pc_adv_d  = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;

    always_comb begin
        pc_jump_d = pc_adv_d;
`ifdef PROC_CTRL_JZ_EN
        if (opc == OP_JZ && z_q) begin
            pc_jump_d = IMEM_AW'({1'b0, imm} % 5'(PROG_LEN));
        end
`endif
    end

    proc_regfile u_regfile (
        .clk_i     (clk),
        .rst_i     (rst),
        .we_i      (rf_we),
        .waddr_i   (rd),
        .wdata_i   (wb_data_d),
        .raddr_a_i (rd),
        .raddr_b_i (rs),
        .rdata_a_o (rdata_a),
        .rdata_b_o (rdata_b),
        .dbg_o     (rf_dbg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            ir_q         <= '0;
            result_q     <= '0;
            fetch_req_q  <= 1'b0;
            instr_addr_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= OP_NOP;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
`ifdef PROC_CTRL_JZ_EN
            z_q          <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_FETCH;
                        fetch_req_q  <= 1'b1;
                        instr_addr_q <= pc_q;
                        busy_q       <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (instr_valid) begin
                        ir_q        <= instr_data;
                        fetch_req_q <= 1'b0;
                        state_q     <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (opc)
                        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                            alu_a_q      <= rdata_a;
                            alu_b_q      <= rdata_b;
                            alu_opcode_q <= opc;
                            state_q      <= ST_EXEC;
                        end
                        OP_LDI: begin
                            state_q <= ST_WB;
                        end
                        OP_HALT: begin
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                            state_q  <= ST_HALT;
                        end
                        default: begin
                            // NOP, and JZ (which collapses to NOP when the jump is not taken/built)
                            pc_q         <= pc_jump_d;
                            instr_addr_q <= pc_jump_d;
                            fetch_req_q  <= 1'b1;
                            state_q      <= ST_FETCH;
                        end
                    endcase
                end
                ST_EXEC: begin
                    result_q <= alu_result;
                    state_q  <= ST_WB;
                end
                ST_WB: begin
                    pc_q         <= pc_adv_d;
                    instr_addr_q <= pc_adv_d;
                    fetch_req_q  <= 1'b1;
                    alu_opcode_q <= OP_NOP;
                    state_q      <= ST_FETCH;
`ifdef PROC_CTRL_JZ_EN
                    z_q          <= (wb_data_d == '0);
`endif
                end
                ST_HALT: begin
                    if (start) begin
                        pc_q         <= '0;
                        instr_addr_q <= '0;
                        fetch_req_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        halted_q     <= 1'b0;
                        state_q      <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fetch_req  = fetch_req_q;
    assign instr_addr = instr_addr_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;
    assign busy       = busy_q;
    assign halted     = halted_q;
`ifdef PROC_CTRL_JZ_EN
    assign z_flag     = z_q;
`endif

endmodule

// File: tb/tb_proc_ctrl.sv
// Directed self-checking bench for proc_ctrl; models the external ALU and instruction memory.
module tb_proc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        fetch_req;
    logic [3:0]  instr_addr;
    logic        instr_valid;
    logic [8:0]  instr_data;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [2:0]  alu_opcode;
    logic [3:0]  alu_result;
    logic        busy;
    logic        halted;
    logic [15:0] rf_dbg;
`ifdef PROC_CTRL_JZ_EN
    logic        z_flag;
`endif

    logic [8:0]  imem [16];
    logic        valid_en;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    proc_ctrl #(.PROG_LEN(16), .IMEM_AW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .fetch_req   (fetch_req),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .busy        (busy),
        .halted      (halted),
`ifdef PROC_CTRL_JZ_EN
        .z_flag      (z_flag),
`endif
        .rf_dbg      (rf_dbg)
    );

    assign instr_data  = imem[instr_addr];
    assign instr_valid = valid_en;

    always_comb begin
        case (alu_opcode)
            3'b001:  alu_result = alu_a + alu_b;
            3'b010:  alu_result = alu_a - alu_b;
            3'b011:  alu_result = alu_a & alu_b;
            3'b100:  alu_result = alu_a | alu_b;
            default: alu_result = 4'h0;
        endcase
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 16; i++) imem[i] = 9'h000;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        valid_en = 1'b1;
        clear_imem();
        step(2);
        rst = 1'b0;
        check("rst_fetch_req", fetch_req, 0);
        check("rst_instr_addr", instr_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_rf_dbg", rf_dbg, 16'h0000);
        check("rst_alu_opcode", alu_opcode, 0);

        // LDI R0,3; LDI R1,5; ADD R0,R1; HALT -> 12 cycles after entering FETCH
        imem[0] = 9'b101_00_0011;
        imem[1] = 9'b101_01_0101;
        imem[2] = 9'b001_00_01_00;
        imem[3] = 9'b111_000000;
        start = 1'b1; step(1); start = 1'b0;
        check("start_fetch_req", fetch_req, 1);
        check("start_busy", busy, 1);
        check("start_instr_addr", instr_addr, 0);
        step(11);
        check("prog1_not_yet_halted", halted, 0);
        step(1);
        check("prog1_halted", halted, 1);
        check("prog1_busy", busy, 0);
        check("prog1_rf", rf_dbg, 16'h0058);

        // SUB wrap and AND, restarted from HALT with registers kept then overwritten
        clear_imem();
        imem[0] = 9'b101_00_0010;
        imem[1] = 9'b101_01_0101;
        imem[2] = 9'b101_10_1100;
        imem[3] = 9'b101_11_1010;
        imem[4] = 9'b010_00_01_00;
        imem[5] = 9'b011_10_11_00;
        imem[6] = 9'b111_000000;
        start = 1'b1; step(1); start = 1'b0;
        check("restart_instr_addr", instr_addr, 0);
        check("restart_halted", halted, 0);
        step(12);
        check("ldi4_instr_addr", instr_addr, 4);
        check("ldi4_rf", rf_dbg, 16'hAC52);
        step(2);
        check("sub_alu_opcode", alu_opcode, 3'b010);
        check("sub_alu_a", alu_a, 4'h2);
        check("sub_alu_b", alu_b, 4'h5);
        step(2);
        check("sub_rf", rf_dbg, 16'hAC5D);
        check("sub_alu_opcode_back", alu_opcode, 0);
        check("sub_instr_addr", instr_addr, 5);
        step(4);
        check("and_rf", rf_dbg, 16'hA85D);
        step(2);
        check("prog2_halted", halted, 1);

        // Fetch stall then NOP sweep through pc wrap
        clear_imem();
        valid_en = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("stall_fetch_req", fetch_req, 1);
            check("stall_instr_addr", instr_addr, 0);
            check("stall_alu_opcode", alu_opcode, 0);
        end
        valid_en = 1'b1;
        step(2);
        check("nop1_instr_addr", instr_addr, 1);
        step(28);
        check("nop15_instr_addr", instr_addr, 15);
        step(2);
        check("nop_wrap_instr_addr", instr_addr, 0);
        check("nop_wrap_fetch_req", fetch_req, 1);

        // Reset mid-fetch, then reset during WB of ADD
        rst = 1'b1; step(1); rst = 1'b0;
        check("rst2_fetch_req", fetch_req, 0);
        check("rst2_busy", busy, 0);
        imem[0] = 9'b101_01_0101;
        imem[1] = 9'b001_00_01_00;
        start = 1'b1; step(1); start = 1'b0;
        step(3);
        check("ldi_r1_rf", rf_dbg, 16'h0050);
        check("ldi_r1_instr_addr", instr_addr, 1);
        step(2);
        start = 1'b1; step(1); start = 1'b0;
        check("wb_alu_opcode", alu_opcode, 3'b001);
        check("wb_busy", busy, 1);
        check("wb_fetch_req", fetch_req, 0);
        check("wb_instr_addr", instr_addr, 1);
        rst = 1'b1; step(1); rst = 1'b0;
        check("rst_wb_rf", rf_dbg, 16'h0000);
        check("rst_wb_busy", busy, 0);
        check("rst_wb_halted", halted, 0);
        check("rst_wb_fetch_req", fetch_req, 0);
        check("rst_wb_instr_addr", instr_addr, 0);
        check("rst_wb_alu_a", alu_a, 0);
        check("rst_wb_alu_b", alu_b, 0);
        check("rst_wb_alu_opcode", alu_opcode, 0);
        step(3);
        check("idle_stays_busy", busy, 0);
        check("idle_stays_fetch_req", fetch_req, 0);

        // SUB R0,R0; JZ 2; then JZ 7 distinguishes a taken jump from NOP
        clear_imem();
        imem[0] = 9'b010_00_00_00;
        imem[1] = 9'b110_00_0010;
        imem[2] = 9'b110_00_0111;
        imem[3] = 9'b111_000000;
        imem[7] = 9'b111_000000;
        start = 1'b1; step(1); start = 1'b0;
        step(4);
        check("subz_rf", rf_dbg, 16'h0000);
        check("subz_instr_addr", instr_addr, 1);
`ifdef PROC_CTRL_JZ_EN
        check("subz_z_flag", z_flag, 1);
`endif
        step(2);
        check("jz2_instr_addr", instr_addr, 2);
        step(2);
`ifdef PROC_CTRL_JZ_EN
        check("jz7_instr_addr", instr_addr, 7);
`else
        check("jz7_as_nop_instr_addr", instr_addr, 3);
`endif
        step(2);
        check("prog5_halted", halted, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
